output_bram_axis_tx: RTL and testbench

OUTPUT_BRAM_AXIS_TX -- requirements
Module: output_bram_axis_tx

---
 rtl/output_bram_axis_tx.sv | 150 +++++++++++++++
 tb/tb_output_bram_axis_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_bram_axis_tx.sv
// output_bram_axis_tx: streams BRAM lines out over AXI-Stream, one DW lane
// per beat, lane 0 first, for an inclusive address range.
// Ports: clk, rst_n (async, active-low); start, addr_start, addr_end launch
// a transfer; bram_rd_en/bram_rd_addr/bram_rd_data_flat read the BRAM with a
// fixed 1-cycle latency; m_axis_tdata/tvalid/tready/tlast form the stream
// master; busy, done (1-cycle pulse) and tx_state report progress.
// Optional feature: define OUTPUT_TX_HEADER_EN to send a MAGIC header beat
// ahead of the data beats.
module output_bram_axis_tx #(
    parameter int              DW         = 16,
    parameter int              NUM_LANES  = 8,
    parameter int              ADDR_WIDTH = 11,
    parameter logic [DW-1:0]   MAGIC      = 16'hA55A
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     addr_start,
    input  logic [ADDR_WIDTH-1:0]     addr_end,
    output logic                      bram_rd_en,
    output logic [ADDR_WIDTH-1:0]     bram_rd_addr,
    input  logic [NUM_LANES*DW-1:0]   bram_rd_data_flat,
    output logic [DW-1:0]             m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                tx_state
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_FETCH  = 3'd2,
        S_LATCH  = 3'd3,
        S_SEND   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   end_q;
    logic [LW-1:0]           lane;
    logic [NUM_LANES*DW-1:0] buffer;

    logic last_lane;
    logic last_addr;

    assign last_lane = (lane == LAST_LANE);
    // Equality compare: an end address at the top of the space never wraps.
    assign last_addr = (addr == end_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr   <= '0;
            end_q  <= '0;
            lane   <= '0;
            buffer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr  <= addr_start;
                        end_q <= addr_end;
                        lane  <= '0;
                        if (addr_end < addr_start) begin
                            state <= S_FIN;
                        end else begin
`ifdef OUTPUT_TX_HEADER_EN
                            state <= S_HEADER;
`else
                            state <= S_FETCH;
`endif
                        end
                    end
                end
                S_HEADER: begin
                    if (m_axis_tready) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    // Read data arrives one cycle after the FETCH request.
                    buffer <= bram_rd_data_flat;
                    lane   <= '0;
                    state  <= S_SEND;
                end
                S_SEND: begin
                    if (m_axis_tready) begin
                        if (last_lane) begin
                            if (last_addr) begin
                                state <= S_FIN;
                            end else begin
                                addr  <= addr + 1'b1;
                                state <= S_FETCH;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        bram_rd_en    = 1'b0;
        bram_rd_addr  = '0;
        case (state)
            S_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = MAGIC;
            end
            S_FETCH: begin
                bram_rd_en   = 1'b1;
                bram_rd_addr = addr;
            end
            S_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = buffer[int'(lane)*DW +: DW];
                m_axis_tlast  = last_lane && last_addr;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign tx_state = state;

endmodule

// File: tb/tb_output_bram_axis_tx.sv
// Testbench for output_bram_axis_tx: table-driven and randomized transfers
// checked against a queue-based beat model and a BRAM model.
module tb_output_bram_axis_tx;

    localparam int DW = 16;
    localparam int NL = 8;
    localparam int AW = 11;
    localparam logic [15:0] MAG = 16'hA55A;
`ifdef OUTPUT_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     addr_start = '0;
    logic [AW-1:0]     addr_end = '0;
    logic              bram_rd_en;
    logic [AW-1:0]     bram_rd_addr;
    logic [NL*DW-1:0]  bram_rd_data_flat;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic [2:0]        tx_state;

    logic [NL*DW-1:0]  mem [0:(1<<AW)-1];

    int total = 0;
    int bad = 0;

    output_bram_axis_tx dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .addr_start(addr_start),
        .addr_end(addr_end),
        .bram_rd_en(bram_rd_en),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data_flat(bram_rd_data_flat),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .done(done),
        .tx_state(tx_state)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bram_rd_en) bram_rd_data_flat <= mem[bram_rd_addr];
    end

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        int s;
        int e;
        int mode;
        int fixed;
        int exp_beats;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] outs();
        return {m_axis_tvalid, m_axis_tlast, m_axis_tdata, bram_rd_en,
                bram_rd_addr, busy, done, tx_state};
    endfunction

    task automatic fill(input int s, input int e, input int fixed);
        for (int a = s; a <= e; a++) begin
            if (fixed != 0) begin
                for (int k = 0; k < NL; k++) mem[a][k*DW +: DW] = 16'(k + 1);
            end else begin
                mem[a] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic run_xfer(input int s, input int e, input int mode,
                            input int fixed, input int exp_beats);
        beat_t q[$];
        int rdq[$];
        int nb = 0, nl = 0, dcyc = -1, viol = 0, unst = 0, mm = 0;
        int nrd;
        logic pv = 0, pr = 0, pl = 0;
        logic [15:0] pd = '0;
        bit fin = 0, ended = 0;
        beat_t b;

        nrd = (e >= s) ? (e - s + 1) : 0;
        if (e >= s) begin
            fill(s, e, fixed);
            if (HDR != 0) begin
                b.d = MAG; b.l = 1'b0; q.push_back(b);
            end
            for (int a = s; a <= e; a++) begin
                for (int k = 0; k < NL; k++) begin
                    b.d = mem[a][k*DW +: DW];
                    b.l = (a == e) && (k == NL - 1);
                    q.push_back(b);
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        addr_start = AW'(s);
        addr_end = AW'(e);
        for (int i = 0; i < 3000 && !ended; i++) begin
            @(negedge clk);
            if (i == 0 || i == 6) start = 1'b0;
            case (mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = (i % 4 == 0) || (i % 4 == 3);
            endcase
            #1;
            if (fin) begin
                chk("done_width", done, 0);
                chk("idle_after", {busy, tx_state}, 0);
                ended = 1;
            end else begin
                if (pv && !pr) begin
                    if (!(m_axis_tvalid && m_axis_tdata == pd &&
                          m_axis_tlast == pl)) unst++;
                end
                if (m_axis_tvalid && !(tx_state == 3'd1 || tx_state == 3'd4))
                    viol++;
                if (bram_rd_en) rdq.push_back(int'(bram_rd_addr));
                if (m_axis_tvalid && m_axis_tready) begin
                    nb++;
                    if (m_axis_tlast) nl++;
                    if (q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        b = q.pop_front();
                        chk("beat", {m_axis_tlast, m_axis_tdata}, {b.l, b.d});
                    end
                end
                if (done) begin
                    dcyc = i + 1;
                    fin = 1;
                end
                pv = m_axis_tvalid;
                pr = m_axis_tready;
                pd = m_axis_tdata;
                pl = m_axis_tlast;
                // A second start mid-transfer must be ignored.
                if (i == 5 && busy) begin
                    start = 1'b1;
                    addr_start = '0;
                    addr_end = '0;
                end
            end
        end
        start = 1'b0;
        if (!ended) chk("timeout", 0, 1);
        chk("beat_count", nb, exp_beats + ((exp_beats > 0) ? HDR : 0));
        chk("tlast_count", nl, (exp_beats > 0) ? 1 : 0);
        if (rdq.size() != nrd) mm++;
        else for (int j = 0; j < nrd; j++) if (rdq[j] != s + j) mm++;
        chk("rd_addrs", mm, 0);
        chk("leftover", q.size(), 0);
        chk("stable_hold", unst, 0);
        chk("valid_outside", viol, 0);
        if (exp_beats == 0) chk("err_done_lat", (dcyc >= 1 && dcyc <= 2), 1);
    endtask

    task automatic reset_mid_send();
        int hs = 0;
        bit hit = 0, tl = 0;
        fill(0, 1, 0);
        @(negedge clk);
        start = 1'b1;
        addr_start = 11'd0;
        addr_end = 11'd1;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            start = 1'b0;
            m_axis_tready = 1'b1;
            #1;
            if (m_axis_tvalid && m_axis_tlast) tl = 1;
            if (m_axis_tvalid && tx_state == 3'd4 && hs == HDR + 3) begin
                chk("pre_rst_lane3", m_axis_tdata, mem[0][3*DW +: DW]);
                #1 rst_n = 1'b0;
                #1 chk("rst_outs_zero", outs(), 0);
                hit = 1;
            end else if (m_axis_tvalid) begin
                hs++;
            end
        end
        if (!hit) chk("rst_timeout", 0, 1);
        chk("rst_no_tlast", tl, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_held_zero", outs(), 0);
        rst_n = 1'b1;
        run_xfer(0, 1, 0, 0, 16);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{s: 5,    e: 5,    mode: 0, fixed: 1, exp_beats: 8};
        vecs[1] = '{s: 0,    e: 3,    mode: 0, fixed: 0, exp_beats: 32};
        vecs[2] = '{s: 10,   e: 9,    mode: 0, fixed: 0, exp_beats: 0};
        vecs[3] = '{s: 2046, e: 2047, mode: 2, fixed: 0, exp_beats: 16};
        vecs[4] = '{s: 7,    e: 9,    mode: 2, fixed: 0, exp_beats: 24};
        vecs[5] = '{s: 100,  e: 101,  mode: 1, fixed: 0, exp_beats: 16};

        #3;
        chk("reset_outs", outs(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("idle_outs", outs(), 0);

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].s, vecs[v].e, vecs[v].mode, vecs[v].fixed,
                     vecs[v].exp_beats);

        for (int r = 0; r < 8; r++) begin
            int s, e;
            s = $urandom_range(0, 2040);
            e = s + $urandom_range(0, 4);
            if (r == 7) e = s - 1;
            run_xfer(s, e, 1, 0, (e >= s) ? (e - s + 1) * NL : 0);
        end

        reset_mid_send();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
